// File: rtl/race_ctrl.sv
// Race sequencer: walks one race through IDLE, COUNTDOWN, RACE and FINISH, counting laps and seconds.
// Optional feature: define RACE_CTRL_CHECKPOINT_EN to require a mid-track checkpoint before each lap counts.
module race_ctrl #(
  parameter int TICK_CYCLES = 65_000_000,
  parameter int COUNT_FROM  = 3,
  parameter int LAPS        = 3,
  parameter int MAX_TIME    = 4095
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        start,
  input  logic        finish_line,
  input  logic        checkpoint,
  input  logic        crash,
  output logic [1:0]  state,
  output logic [1:0]  countdown,
  output logic [3:0]  lap,
  output logic [11:0] race_time,
  output logic        go,
  output logic        win
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COUNTDOWN = 2'd1,
    S_RACE      = 2'd2,
    S_FINISH    = 2'd3
  } phase_t;

  localparam int              TW         = $clog2(TICK_CYCLES);
  localparam logic [TW-1:0]   TICK_LAST  = TW'(TICK_CYCLES - 1);
  localparam logic [1:0]      CD_INIT    = 2'(COUNT_FROM);
  localparam logic [3:0]      LAP_WIN    = 4'(LAPS);
  localparam logic [11:0]     TIME_LIMIT = 12'(MAX_TIME);

  phase_t         state_q, state_d;
  logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
  logic [1:0]     cd_q, cd_d;
  logic [3:0]     lap_q, lap_d;
  logic [11:0]    time_q, time_d;
  logic           go_q, go_d;
  logic           win_q, win_d;
  logic           running;
  logic           tick;
  logic           lap_hit;

  assign running = (state_q == S_COUNTDOWN) || (state_q == S_RACE);
  assign tick    = running && (tick_cnt_q == TICK_LAST);

`ifdef RACE_CTRL_CHECKPOINT_EN
  logic armed_q, armed_d;

  // A checkpoint in the same cycle wins: it arms, and the crossing is ignored.
  assign lap_hit = finish_line && armed_q && !checkpoint;

  always_comb begin
    armed_d = armed_q;
    if (state_q != S_RACE)  armed_d = 1'b0;
    else if (checkpoint)    armed_d = 1'b1;
    else if (lap_hit)       armed_d = 1'b0;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) armed_q <= 1'b0;
    else     armed_q <= armed_d;
  end
`else
  logic unused_checkpoint;
  assign unused_checkpoint = checkpoint;
  assign lap_hit           = finish_line;
`endif

  // NOTE: every variable gets its hold value first so no path through the case can infer a latch.
  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    lap_d   = lap_q;
    time_d  = time_q;
    win_d   = win_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_COUNTDOWN;
          cd_d    = CD_INIT;
          lap_d   = '0;
          time_d  = '0;
          win_d   = 1'b0;
        end
      end
      S_COUNTDOWN: begin
        if (tick) begin
          if (cd_q == 2'd1) begin
            state_d = S_RACE;
            cd_d    = '0;
          end else begin
            cd_d = cd_q - 2'd1;
          end
        end
      end
      S_RACE: begin
        if (crash) begin
          state_d = S_FINISH;
          win_d   = 1'b0;
        end else if (lap_hit && (lap_q + 4'd1 == LAP_WIN)) begin
          state_d = S_FINISH;
          win_d   = 1'b1;
          lap_d   = LAP_WIN;
        end else begin
          if (lap_hit) lap_d = lap_q + 4'd1;
          if (tick) begin
            time_d = time_q + 12'd1;
            if (time_q + 12'd1 == TIME_LIMIT) begin
              state_d = S_FINISH;
              win_d   = 1'b0;
            end
          end
        end
      end
      S_FINISH: begin
        if (start) begin
          state_d = S_IDLE;
          cd_d    = '0;
          lap_d   = '0;
          time_d  = '0;
          win_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    go_d = (state_d == S_RACE);

    // Restarting on each phase change makes the first tick land exactly TICK_CYCLES after entry.
    if (!running || tick || (state_d != state_q)) tick_cnt_d = '0;
    else                                          tick_cnt_d = tick_cnt_q + TW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      cd_q       <= '0;
      lap_q      <= '0;
      time_q     <= '0;
      go_q       <= 1'b0;
      win_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      cd_q       <= cd_d;
      lap_q      <= lap_d;
      time_q     <= time_d;
      go_q       <= go_d;
      win_q      <= win_d;
    end
  end

  assign state     = state_q;
  assign countdown = cd_q;
  assign lap       = lap_q;
  assign race_time = time_q;
  assign go        = go_q;
  assign win       = win_q;

endmodule

// File: tb/tb_race_ctrl.sv
// Self-checking bench for race_ctrl: directed scenarios with hand-derived values plus a random run against a phase-level model.
module tb_race_ctrl;

  localparam int TICK   = 10;
  localparam int CFROM  = 3;
  localparam int NLAPS  = 2;
  localparam int TMAX   = 5;

  logic        pclk;
  logic        rst;
  logic        start, finish_line, checkpoint, crash;
  logic [1:0]  state, countdown;
  logic [3:0]  lap;
  logic [11:0] race_time;
  logic        go, win;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: phase, shown digit, laps, seconds, result, cycles spent in the phase.
  int m_state, m_cd, m_lap, m_time, m_win, m_elapsed;
  bit m_armed;

  race_ctrl #(
    .TICK_CYCLES(TICK),
    .COUNT_FROM (CFROM),
    .LAPS       (NLAPS),
    .MAX_TIME   (TMAX)
  ) dut (
    .pclk       (pclk),
    .rst        (rst),
    .start      (start),
    .finish_line(finish_line),
    .checkpoint (checkpoint),
    .crash      (crash),
    .state      (state),
    .countdown  (countdown),
    .lap        (lap),
    .race_time  (race_time),
    .go         (go),
    .win        (win)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  function automatic logic [21:0] obs();
    return {state, countdown, lap, race_time, go, win};
  endfunction

  function automatic logic [21:0] ex(input int st, input int cd, input int lp,
                                     input int t, input int g, input int w);
    return {2'(st), 2'(cd), 4'(lp), 12'(t), 1'(g), 1'(w)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_cd = 0; m_lap = 0; m_time = 0; m_win = 0; m_elapsed = 0; m_armed = 0;
  endtask

  // One second elapses each time TICK whole cycles have been spent in COUNTDOWN or RACE.
  task automatic model_step(input bit s, input bit f, input bit cp, input bit cr);
    bit tick, counts;
    int ns;
    tick = (m_state == 1 || m_state == 2) && ((m_elapsed + 1) % TICK == 0);
    ns   = m_state;
    case (m_state)
      0: if (s) begin ns = 1; m_cd = CFROM; m_lap = 0; m_time = 0; m_win = 0; end
      1: if (tick) begin
           if (m_cd == 1) begin ns = 2; m_cd = 0; m_armed = 0; end
           else m_cd = m_cd - 1;
         end
      2: begin
`ifdef RACE_CTRL_CHECKPOINT_EN
           counts = f && m_armed && !cp;
           if (cp) m_armed = 1;
           else if (counts) m_armed = 0;
`else
           counts = f;
`endif
           if (cr) begin ns = 3; m_win = 0; end
           else if (counts && m_lap + 1 == NLAPS) begin ns = 3; m_win = 1; m_lap = NLAPS; end
           else begin
             if (counts) m_lap = m_lap + 1;
             if (tick) begin
               m_time = m_time + 1;
               if (m_time == TMAX) begin ns = 3; m_win = 0; end
             end
           end
         end
      default: if (s) begin ns = 0; m_cd = 0; m_lap = 0; m_time = 0; m_win = 0; end
    endcase
    m_elapsed = (ns != m_state) ? 0 : m_elapsed + 1;
    m_state   = ns;
  endtask

  // Drive one cycle of inputs, let the edge sample them, and settle 1 time unit after it.
  task automatic step(input bit s, input bit f, input bit cp, input bit cr);
    start = s; finish_line = f; checkpoint = cp; crash = cr;
    @(posedge pclk);
    model_step(s, f, cp, cr);
    #1;
    start = 0; finish_line = 0; checkpoint = 0; crash = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic go_to_race();
    step(1, 0, 0, 0);
    idle(CFROM * TICK);
    n_tests++;
    if (obs() !== ex(2, 0, 0, 0, 1, 0)) begin
      n_fail++; $display("FAIL race_entry: got %h expected %h", obs(), ex(2, 0, 0, 0, 1, 0));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; finish_line = 0; checkpoint = 0; crash = 0;
    model_reset();
    #7;
    n_tests++;
    if (obs() !== ex(0, 0, 0, 0, 0, 0)) begin
      n_fail++; $display("FAIL reset: got %h expected %h", obs(), ex(0, 0, 0, 0, 0, 0));
    end
    @(negedge pclk); rst = 1'b0;
    step(0, 0, 0, 0);
    n_tests++;
    if (obs() !== ex(0, 0, 0, 0, 0, 0)) begin
      n_fail++; $display("FAIL idle_after_reset: got %h expected %h", obs(), ex(0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_countdown();
    step(1, 0, 0, 0);
    n_tests++;
    if (obs() !== ex(1, 3, 0, 0, 0, 0)) begin
      n_fail++; $display("FAIL cd_enter: got %h expected %h", obs(), ex(1, 3, 0, 0, 0, 0));
    end
    idle(9);
    n_tests++;
    if (obs() !== ex(1, 3, 0, 0, 0, 0)) begin
      n_fail++; $display("FAIL cd_hold3: got %h expected %h", obs(), ex(1, 3, 0, 0, 0, 0));
    end
    step(1, 1, 1, 1);
    n_tests++;
    if (obs() !== ex(1, 2, 0, 0, 0, 0)) begin
      n_fail++; $display("FAIL cd_2: got %h expected %h", obs(), ex(1, 2, 0, 0, 0, 0));
    end
    idle(10);
    n_tests++;
    if (obs() !== ex(1, 1, 0, 0, 0, 0)) begin
      n_fail++; $display("FAIL cd_1: got %h expected %h", obs(), ex(1, 1, 0, 0, 0, 0));
    end
    idle(9);
    n_tests++;
    if (obs() !== ex(1, 1, 0, 0, 0, 0)) begin
      n_fail++; $display("FAIL cd_29: got %h expected %h", obs(), ex(1, 1, 0, 0, 0, 0));
    end
    step(1, 0, 0, 0);
    n_tests++;
    if (obs() !== ex(2, 0, 0, 0, 1, 0)) begin
      n_fail++; $display("FAIL cd_30_race: got %h expected %h", obs(), ex(2, 0, 0, 0, 1, 0));
    end
  endtask

  task automatic test_timeout();
    for (int k = 1; k < TMAX; k++) begin
      idle(TICK);
      n_tests++;
      if (obs() !== ex(2, 0, 0, k, 1, 0)) begin
        n_fail++; $display("FAIL time_%0d: got %h expected %h", k, obs(), ex(2, 0, 0, k, 1, 0));
      end
    end
    idle(TICK);
    n_tests++;
    if (obs() !== ex(3, 0, 0, TMAX, 0, 0)) begin
      n_fail++; $display("FAIL timeout_lose: got %h expected %h", obs(), ex(3, 0, 0, TMAX, 0, 0));
    end
    for (int i = 0; i < 15; i++) step(0, 1, 1, 1);
    n_tests++;
    if (obs() !== ex(3, 0, 0, TMAX, 0, 0)) begin
      n_fail++; $display("FAIL finish_frozen: got %h expected %h", obs(), ex(3, 0, 0, TMAX, 0, 0));
    end
    step(1, 0, 0, 0);
    n_tests++;
    if (obs() !== ex(0, 0, 0, 0, 0, 0)) begin
      n_fail++; $display("FAIL finish_to_idle: got %h expected %h", obs(), ex(0, 0, 0, 0, 0, 0));
    end
  endtask

`ifndef RACE_CTRL_CHECKPOINT_EN
  task automatic test_two_laps();
    go_to_race();
    idle(4);
    step(0, 1, 0, 0);
    n_tests++;
    if (obs() !== ex(2, 0, 1, 0, 1, 0)) begin
      n_fail++; $display("FAIL lap1: got %h expected %h", obs(), ex(2, 0, 1, 0, 1, 0));
    end
    idle(6);
    n_tests++;
    if (obs() !== ex(2, 0, 1, 1, 1, 0)) begin
      n_fail++; $display("FAIL lap1_time1: got %h expected %h", obs(), ex(2, 0, 1, 1, 1, 0));
    end
    step(0, 1, 0, 0);
    n_tests++;
    if (obs() !== ex(3, 0, 2, 1, 0, 1)) begin
      n_fail++; $display("FAIL win: got %h expected %h", obs(), ex(3, 0, 2, 1, 0, 1));
    end
    step(1, 0, 0, 0);
  endtask

  task automatic test_crash_final();
    go_to_race();
    step(0, 1, 0, 0);
    n_tests++;
    if (obs() !== ex(2, 0, 1, 0, 1, 0)) begin
      n_fail++; $display("FAIL crash_lap1: got %h expected %h", obs(), ex(2, 0, 1, 0, 1, 0));
    end
    step(0, 1, 0, 1);
    n_tests++;
    if (obs() !== ex(3, 0, 1, 0, 0, 0)) begin
      n_fail++; $display("FAIL crash_beats_lap: got %h expected %h", obs(), ex(3, 0, 1, 0, 0, 0));
    end
    step(1, 0, 0, 0);
  endtask
`else
  task automatic test_checkpoint();
    go_to_race();
    step(0, 1, 0, 0);
    n_tests++;
    if (lap !== 4'd0) begin n_fail++; $display("FAIL cp_unarmed: got %0d expected 0", lap); end
    step(0, 0, 1, 0);
    n_tests++;
    if (lap !== 4'd0) begin n_fail++; $display("FAIL cp_arm: got %0d expected 0", lap); end
    step(0, 1, 0, 0);
    n_tests++;
    if (lap !== 4'd1) begin n_fail++; $display("FAIL cp_lap1: got %0d expected 1", lap); end
    step(0, 1, 1, 0);
    n_tests++;
    if (lap !== 4'd1) begin n_fail++; $display("FAIL cp_same_cycle: got %0d expected 1", lap); end
    step(0, 1, 0, 0);
    n_tests++;
    if (obs() !== ex(3, 0, 2, 0, 0, 1)) begin
      n_fail++; $display("FAIL cp_win: got %h expected %h", obs(), ex(3, 0, 2, 0, 0, 1));
    end
    step(1, 0, 0, 0);
  endtask
`endif

  task automatic test_async_reset();
    go_to_race();
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    n_tests++;
    if (lap !== 4'd1) begin n_fail++; $display("FAIL pre_reset_lap: got %0d expected 1", lap); end
    rst = 1'b1;
    #2;
    n_tests++;
    if (obs() !== ex(0, 0, 0, 0, 0, 0)) begin
      n_fail++; $display("FAIL async_reset: got %h expected %h", obs(), ex(0, 0, 0, 0, 0, 0));
    end
    model_reset();
    @(negedge pclk); rst = 1'b0;
    step(1, 0, 0, 0);
    n_tests++;
    if (obs() !== ex(1, 3, 0, 0, 0, 0)) begin
      n_fail++; $display("FAIL restart_cd: got %h expected %h", obs(), ex(1, 3, 0, 0, 0, 0));
    end
    idle(CFROM * TICK - 1);
    crash = 1'b1;
    @(posedge pclk); model_step(0, 0, 0, 1); #1; crash = 1'b0;
    step(1, 0, 0, 0);
  endtask

  task automatic test_random();
    bit s, f, cp, cr;
    logic [21:0] want;
    for (int i = 0; i < 4000; i++) begin
      s  = ($urandom_range(0, 99) < 4);
      f  = ($urandom_range(0, 99) < 8);
      cp = ($urandom_range(0, 99) < 10);
      cr = ($urandom_range(0, 199) < 1);
      step(s, f, cp, cr);
      want = ex(m_state, m_cd, m_lap, m_time, (m_state == 2) ? 1 : 0, m_win);
      n_tests++;
      if (obs() !== want) begin
        n_fail++; $display("FAIL random_cycle_%0d: got %h expected %h", i, obs(), want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_timeout();
`ifndef RACE_CTRL_CHECKPOINT_EN
    test_two_laps();
    test_crash_final();
`else
    test_checkpoint();
`endif
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
